fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_queue.sv | 59 +++++
 rtl/fetch_unit.sv | 73 +++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order instruction queue; entry 0 is always the head.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam fetch_entry_t RESET_ENTRY = '{pc: 32'h0, inst: NOP_INST};

    fetch_entry_t ent0, ent1;
    logic [1:0]   count;

    assign full  = (count == 2'(DEPTH));
    assign empty = (count == 2'd0);
    assign head  = ent0;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            ent0  <= RESET_ENTRY;
            ent1  <= RESET_ENTRY;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) ent0 <= push_entry;
                    else               ent1 <= push_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                // Simultaneous push/pop keeps the count; new entry lands behind the survivor.
                2'b11: begin
                    if (count == 2'd1) begin
                        ent0 <= push_entry;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: pc sequencing, redirect handling and a 2-deep queue to decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        de_ready,
    output logic        de_valid,
    output logic [31:0] de_inst,
    output logic [31:0] de_pc,
    output logic        fetch_err
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         redir_act, redir_ok;
    logic         push, pop;
    logic         q_full, q_empty;
    fetch_entry_t head;

    assign redir_act = redirect_valid && (state != HALT);
    assign redir_ok  = (redirect_pc[1:0] == 2'b00);

    assign de_valid  = !q_empty;
    assign de_inst   = head.inst;
    assign de_pc     = head.pc;
    assign imem_addr = pc;

    assign pop  = de_valid && de_ready;
    assign push = (state == RUN) && fetch_en && !redir_act && (!q_full || pop);

    fetch_queue #(
        .DEPTH(QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (redir_act),
        .push_entry ('{pc: pc, inst: imem_data}),
        .full       (q_full),
        .empty      (q_empty),
        .head       (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            fetch_err <= 1'b0;
        end else if (redir_act && !redir_ok) begin
            state     <= HALT;
            fetch_err <= 1'b1;
        end else begin
            if (redir_act)  pc <= redirect_pc;
            else if (push)  pc <= pc + 32'd4;
            case (state)
                IDLE:    if (fetch_en) state <= RUN;
                RUN:     if (!fetch_en && !redirect_valid) state <= IDLE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an expected-delivery scoreboard on the decode port.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        de_ready;
    logic        de_valid;
    logic [31:0] de_inst;
    logic [31:0] de_pc;
    logic        fetch_err;

    int n_vec = 0;
    int n_err = 0;
    fetch_entry_t exp_q[$];

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .QDEPTH  (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .de_ready       (de_ready),
        .de_valid       (de_valid),
        .de_inst        (de_inst),
        .de_pc          (de_pc),
        .fetch_err      (fetch_err)
    );

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a), mem_byte(a + 32'd1), mem_byte(a + 32'd2), mem_byte(a + 32'd3)};
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst);
        exp_q.push_back('{pc: pc, inst: inst});
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // A transfer happens at the coming edge unless reset or a redirect flush overrides it.
    always @(negedge clk) begin
        if (!rst && de_valid && de_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_delivery", de_pc, 32'hDEAD_BEEF);
            end else begin
                fetch_entry_t e;
                e = exp_q.pop_front();
                check("deliver_pc", de_pc, e.pc);
                check("deliver_inst", de_inst, e.inst);
            end
        end
    end

    initial begin
        rst = 1'b1; fetch_en = 1'b0; de_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        tick(2);
        rst = 1'b0;
        check("rst_de_valid", 32'(de_valid), 32'd0);
        check("rst_de_inst", de_inst, 32'h0000_0013);
        check("rst_de_pc", de_pc, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);

        // Streaming: 0, 4, 8, C delivered back to back.
        push_exp(32'h0, 32'h5A5B_5859);
        push_exp(32'h4, mem_word(32'h4));
        push_exp(32'h8, mem_word(32'h8));
        push_exp(32'hC, mem_word(32'hC));
        fetch_en = 1'b1; de_ready = 1'b1;
        tick();
        check("run_entry_no_valid", 32'(de_valid), 32'd0);
        tick();
        check("first_valid", 32'(de_valid), 32'd1);
        check("first_pc", de_pc, 32'h0);
        tick(4);
        de_ready = 1'b0;
        do_reset();

        // Backpressure: queue fills with 0 and 4, pc parks at 8.
        fetch_en = 1'b1; de_ready = 1'b0;
        tick(8);
        check("bp_de_valid", 32'(de_valid), 32'd1);
        check("bp_head_pc", de_pc, 32'h0);
        check("bp_imem_addr", imem_addr, 32'h8);
        push_exp(32'h0, 32'h5A5B_5859);
        push_exp(32'h4, mem_word(32'h4));
        push_exp(32'h8, mem_word(32'h8));
        de_ready = 1'b1;
        tick(3);

        // Redirect against a full queue with a pop pending.
        check("pre_redir_head", de_pc, 32'hC);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("redir_flush_valid", 32'(de_valid), 32'd0);
        check("redir_imem_addr", imem_addr, 32'h40);
        push_exp(32'h40, mem_word(32'h40));
        tick();
        check("redir_target_pc", de_pc, 32'h40);
        tick();
        de_ready = 1'b0;
        tick(2);

        // Reset while the queue holds two entries.
        check("midrun_full_valid", 32'(de_valid), 32'd1);
        do_reset();
        check("midrst_de_valid", 32'(de_valid), 32'd0);
        check("midrst_imem_addr", imem_addr, 32'h0);
        check("midrst_fetch_err", 32'(fetch_err), 32'd0);

        // Misaligned redirect halts; later redirects ignored; only reset recovers.
        fetch_en = 1'b1; de_ready = 1'b0;
        tick(2);
        check("pre_mis_imem_addr", imem_addr, 32'h4);
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        tick();
        redirect_valid = 1'b0;
        check("mis_fetch_err", 32'(fetch_err), 32'd1);
        check("mis_de_valid", 32'(de_valid), 32'd0);
        check("mis_imem_addr", imem_addr, 32'h4);
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        redirect_valid = 1'b0;
        check("halt_ignore_redir", imem_addr, 32'h4);
        de_ready = 1'b1;
        tick(3);
        check("halt_no_fetch", 32'(de_valid), 32'd0);
        check("halt_err_sticky", 32'(fetch_err), 32'd1);
        check("halt_pc_held", imem_addr, 32'h4);
        fetch_en = 1'b0; de_ready = 1'b0;
        do_reset();
        check("halt_rst_err", 32'(fetch_err), 32'd0);
        check("halt_rst_addr", imem_addr, 32'h0);

        // Wrap at the top of the address space, then pause while the queue drains.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; fetch_en = 1'b1;
        tick();
        redirect_valid = 1'b0;
        check("wrap_redir_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_pc_zero", imem_addr, 32'h0);
        tick();
        push_exp(32'hFFFF_FFFC, 32'h5958_5B5A);
        push_exp(32'h0, 32'h5A5B_5859);
        fetch_en = 1'b0; de_ready = 1'b1;
        tick(3);
        check("pause_pc_held", imem_addr, 32'h4);
        check("pause_drained", 32'(de_valid), 32'd0);
        push_exp(32'h4, mem_word(32'h4));
        fetch_en = 1'b1;
        tick(2);
        check("resume_pc", de_pc, 32'h4);
        tick();
        fetch_en = 1'b0; de_ready = 1'b0;
        tick(3);

        check("scoreboard_left", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
